// File: rtl/led_pwm_mux.sv
// led_pwm_mux: double-buffered PWM scanner for common-sink multiplexed RGB LEDs.
// Sinks (ledrgb) are scanned one phase at a time. Each phase starts with a blanking gap,
// then 2^PWM_BITS duty slots in which the source lines (ledc) compare against the front buffer.
module led_pwm_mux #(
    parameter int NUM_LEDS   = 11,
    parameter int NUM_PHASES = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALE   = 0,
    parameter int DEAD_TIME  = 2,
    parameter logic [2*NUM_PHASES*NUM_LEDS-1:0] LED_MAP = {NUM_LEDS{(2*NUM_PHASES)'(8'hE4)}}
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic                        wr_en,
    input  logic [$clog2(NUM_LEDS)-1:0] wr_led,
    input  logic [1:0]                  wr_color,
    input  logic [PWM_BITS-1:0]         wr_data,
    input  logic                        swap_req,
    output logic                        swap_pending,
    output logic                        swap_done,
    output logic                        frame_start,
    output logic [NUM_LEDS-1:0]         ledc,
    output logic [NUM_PHASES-1:0]       ledrgb
);

    localparam int DEAD_W = (DEAD_TIME > 1) ? $clog2(DEAD_TIME) : 1;
    localparam int PRE_W  = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;

    localparam logic [DEAD_W-1:0]   DEAD_LAST  = DEAD_W'(DEAD_TIME - 1);
    localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(PRESCALE);
    localparam logic [1:0]          PHASE_LAST = 2'(NUM_PHASES - 1);
    localparam logic [PWM_BITS-1:0] SLOT_LAST  = '1;

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        ACTIVE
    } state_t;

    state_t                r_state;
    state_t                w_stateNext;
    logic [1:0]            r_phase;
    logic [1:0]            w_phaseNext;
    logic [PWM_BITS-1:0]   r_slot;
    logic [PWM_BITS-1:0]   w_slotNext;
    logic [DEAD_W-1:0]     r_dead;
    logic [DEAD_W-1:0]     w_deadNext;
    logic [PRE_W-1:0]      r_pre;
    logic [PRE_W-1:0]      w_preNext;
    logic                  w_frameBegin;
    logic                  w_frameEnd;
    logic                  w_swapNow;
    logic                  w_wrValid;
    logic [1:0]            w_wrPhase;

    logic                  r_front;
    logic                  r_swapPending;
    logic                  r_swapDone;
    logic                  r_frameStart;
    logic [NUM_LEDS-1:0]   r_ledc;
    logic [NUM_PHASES-1:0] r_ledrgb;

    // Two frame buffers; r_front selects the displayed one, the other is the host's back buffer.
    logic [PWM_BITS-1:0]   r_buf [2][NUM_LEDS][NUM_PHASES];

    // Scan state and counters advance every clock; everything returns to zero in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_phase <= '0;
            r_slot  <= '0;
            r_dead  <= '0;
            r_pre   <= '0;
        end else begin
            r_state <= w_stateNext;
            r_phase <= w_phaseNext;
            r_slot  <= w_slotNext;
            r_dead  <= w_deadNext;
            r_pre   <= w_preNext;
        end
    end

    // Next-state logic: blank gap, slot/prescale counting, phase stepping and frame boundary.
    always_comb begin
        w_stateNext  = r_state;
        w_phaseNext  = r_phase;
        w_slotNext   = r_slot;
        w_deadNext   = r_dead;
        w_preNext    = r_pre;
        w_frameBegin = 1'b0;
        w_frameEnd   = 1'b0;
        if (!enable) begin
            w_stateNext = IDLE;
            w_phaseNext = '0;
            w_slotNext  = '0;
            w_deadNext  = '0;
            w_preNext   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_stateNext  = BLANK;
                    w_phaseNext  = '0;
                    w_deadNext   = '0;
                    w_frameBegin = 1'b1;
                end
                BLANK: begin
                    if (r_dead == DEAD_LAST) begin
                        w_stateNext = ACTIVE;
                        w_deadNext  = '0;
                        w_slotNext  = '0;
                        w_preNext   = '0;
                    end else begin
                        w_deadNext = r_dead + DEAD_W'(1);
                    end
                end
                ACTIVE: begin
                    if (r_pre == PRE_LAST) begin
                        w_preNext = '0;
                        if (r_slot == SLOT_LAST) begin
                            w_slotNext  = '0;
                            w_stateNext = BLANK;
                            if (r_phase == PHASE_LAST) begin
                                w_phaseNext  = '0;
                                w_frameBegin = 1'b1;
                                w_frameEnd   = 1'b1;
                            end else begin
                                w_phaseNext = r_phase + 2'd1;
                            end
                        end else begin
                            w_slotNext = r_slot + PWM_BITS'(1);
                        end
                    end else begin
                        w_preNext = r_pre + PRE_W'(1);
                    end
                end
                default: begin
                    w_stateNext = IDLE;
                end
            endcase
        end
    end

    // Translate the logical colour of a write into its physical phase and reject out-of-range targets.
    always_comb begin
        w_wrPhase = 2'd0;
        w_wrValid = 1'b0;
        if (int'(wr_led) < NUM_LEDS && int'(wr_color) < NUM_PHASES) begin
            w_wrPhase = LED_MAP[(int'(wr_led) * NUM_PHASES + int'(wr_color)) * 2 +: 2];
            w_wrValid = wr_en && (int'(w_wrPhase) < NUM_PHASES);
        end
    end

    assign w_swapNow = (r_swapPending || swap_req) && (r_state == IDLE || w_frameEnd);

    // Host writes always target the buffer that is not being displayed at this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int l = 0; l < NUM_LEDS; l++) begin
                    for (int p = 0; p < NUM_PHASES; p++) begin
                        r_buf[b][l][p] <= '0;
                    end
                end
            end
        end else if (w_wrValid) begin
            r_buf[~r_front][wr_led][w_wrPhase] <= wr_data;
        end
    end

    // Swap handshake and frame pulses; a swap is held pending until the frame boundary (or IDLE).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_front       <= 1'b0;
            r_swapPending <= 1'b0;
            r_swapDone    <= 1'b0;
            r_frameStart  <= 1'b0;
        end else begin
            r_front       <= r_front ^ w_swapNow;
            r_swapPending <= w_swapNow ? 1'b0 : (r_swapPending || swap_req);
            r_swapDone    <= w_swapNow;
            r_frameStart  <= w_frameBegin;
        end
    end

    // Registered LED drive: sink and PWM sources follow the scan state one clock later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ledc   <= '0;
            r_ledrgb <= '0;
        end else if (enable && r_state == ACTIVE) begin
            r_ledrgb <= NUM_PHASES'(1) << r_phase;
            for (int l = 0; l < NUM_LEDS; l++) begin
                r_ledc[l] <= (r_slot < r_buf[r_front][l][r_phase]);
            end
        end else begin
            r_ledc   <= '0;
            r_ledrgb <= '0;
        end
    end

    assign swap_pending = r_swapPending;
    assign swap_done    = r_swapDone;
    assign frame_start  = r_frameStart;
    assign ledc         = r_ledc;
    assign ledrgb       = r_ledrgb;

endmodule

// File: tb/tb_led_pwm_mux.sv
// tb_led_pwm_mux: directed scoreboard bench for led_pwm_mux with a 27-clock frame
// (3 LEDs, 3 phases, 3-bit duty, no prescale, 1 blank clock per phase).
module tb_led_pwm_mux;

    localparam int DEAD   = 1;
    localparam int PH_LEN = DEAD + 8;
    localparam int FRAME  = 3 * PH_LEN;

    typedef struct packed {
        logic       fs;
        logic       sd;
        logic       sp;
        logic [2:0] rgb;
        logic [2:0] c;
    } outs_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       wr_en;
    logic [1:0] wr_led;
    logic [1:0] wr_color;
    logic [2:0] wr_data;
    logic       swap_req;
    logic       swap_pending;
    logic       swap_done;
    logic       frame_start;
    logic [2:0] ledc;
    logic [2:0] ledrgb;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    // Bench reference: where the scan is in the frame, the two buffers and the pending request.
    int         mPos;
    bit         mFront;
    bit         mPend;
    logic [2:0] mBuf [2][3][3];
    int         benchMap [3][3] = '{'{0, 1, 2}, '{2, 1, 0}, '{0, 1, 2}};

    outs_t sbQ [$];

    int cntFs;
    int cntSd;
    int cntLed [3];
    int cntLP [3][3];

    led_pwm_mux #(
        .NUM_LEDS   (3),
        .NUM_PHASES (3),
        .PWM_BITS   (3),
        .PRESCALE   (0),
        .DEAD_TIME  (1),
        .LED_MAP    ({6'b100100, 6'b000110, 6'b100100})
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .wr_en        (wr_en),
        .wr_led       (wr_led),
        .wr_color     (wr_color),
        .wr_data      (wr_data),
        .swap_req     (swap_req),
        .swap_pending (swap_pending),
        .swap_done    (swap_done),
        .frame_start  (frame_start),
        .ledc         (ledc),
        .ledrgb       (ledrgb)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic modelReset();
        mPos   = -1;
        mFront = 1'b0;
        mPend  = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int l = 0; l < 3; l++)
                for (int p = 0; p < 3; p++)
                    mBuf[b][l][p] = 3'd0;
    endtask

    task automatic clearCounts();
        cntFs = 0;
        cntSd = 0;
        for (int l = 0; l < 3; l++) begin
            cntLed[l] = 0;
            for (int p = 0; p < 3; p++) cntLP[l][p] = 0;
        end
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One clock: predict the registered outputs from the current inputs, push, clock, pop and compare.
    task automatic applyStimulus();
        outs_t e;
        outs_t obs;
        int    prev;
        int    p;
        int    r;
        int    s;
        bit    fEnd;
        bit    sw;
        prev = mPos;
        e = '0;
        if (enable && prev >= 0) begin
            p = prev / PH_LEN;
            r = prev % PH_LEN;
            if (r >= DEAD) begin
                s = r - DEAD;
                e.rgb = 3'(1 << p);
                for (int l = 0; l < 3; l++) e.c[l] = (s < int'(mBuf[mFront][l][p]));
            end
        end
        fEnd = enable && (prev == FRAME - 1);
        e.fs = enable && (prev < 0 || fEnd);
        sw   = (mPend || swap_req) && (prev < 0 || fEnd);
        if (wr_en && wr_led < 2'd3 && wr_color < 2'd3)
            mBuf[~mFront][int'(wr_led)][benchMap[wr_led][wr_color]] = wr_data;
        if (sw) begin
            mFront = ~mFront;
            mPend  = 1'b0;
        end else if (swap_req) begin
            mPend = 1'b1;
        end
        mPos = !enable ? -1 : ((prev < 0) ? 0 : (prev + 1) % FRAME);
        e.sd = sw;
        e.sp = mPend;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        cycle++;
        obs = {frame_start, swap_done, swap_pending, ledrgb, ledc};
        e = sbQ.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("[TB] FAIL scoreboard cycle=%0d observed=%b expected=%b", cycle, obs, e);
        end
        cntFs += int'(frame_start);
        cntSd += int'(swap_done);
        for (int l = 0; l < 3; l++) begin
            cntLed[l] += int'(ledc[l]);
            for (int q = 0; q < 3; q++) cntLP[l][q] += int'(ledc[l] && ledrgb[q]);
        end
    endtask

    task automatic doWrite(input int l, input int c, input int d);
        wr_en    = 1'b1;
        wr_led   = 2'(l);
        wr_color = 2'(c);
        wr_data  = 3'(d);
        applyStimulus();
        wr_en    = 1'b0;
    endtask

    task automatic requestSwap();
        swap_req = 1'b1;
        applyStimulus();
        swap_req = 1'b0;
    endtask

    task automatic waitPos(input int target);
        int n;
        n = 0;
        while (mPos != target && n < 3 * FRAME) begin
            applyStimulus();
            n++;
        end
        checkOutput("waitPos reached", mPos, target);
    endtask

    task automatic runFrame();
        repeat (FRAME) applyStimulus();
    endtask

    // Directed sequence: idle scan, swaps, colour remap, absorbed requests, boundary swap, reset/enable.
    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        wr_en    = 1'b0;
        wr_led   = 2'd0;
        wr_color = 2'd0;
        wr_data  = 3'd0;
        swap_req = 1'b0;
        modelReset();
        clearCounts();
        #3;
        checkOutput("reset outputs", int'({frame_start, swap_done, swap_pending, ledrgb, ledc}), 0);
        rst = 1'b0;

        $display("[TB] step 1: empty buffers scan");
        enable = 1'b1;
        repeat (55) applyStimulus();
        checkOutput("frame_start count in 55 clocks", cntFs, 3);
        checkOutput("ledc dark with empty buffers", cntLed[0] + cntLed[1] + cntLed[2], 0);

        $display("[TB] step 2: write and swap");
        doWrite(0, 0, 3);
        doWrite(1, 1, 7);
        doWrite(2, 2, 0);
        requestSwap();
        checkOutput("swap_pending after request", int'(swap_pending), 1);
        waitPos(FRAME - 1);
        clearCounts();
        runFrame();
        checkOutput("step2 swap_done count", cntSd, 1);
        checkOutput("step2 led0 phase0", cntLP[0][0], 3);
        checkOutput("step2 led0 total", cntLed[0], 3);
        checkOutput("step2 led1 phase1", cntLP[1][1], 7);
        checkOutput("step2 led1 total", cntLed[1], 7);
        checkOutput("step2 led2 total", cntLed[2], 0);

        $display("[TB] step 3: remapped colour");
        doWrite(1, 0, 5);
        requestSwap();
        waitPos(FRAME - 1);
        clearCounts();
        runFrame();
        checkOutput("step3 led1 phase2", cntLP[1][2], 5);
        checkOutput("step3 led1 total", cntLed[1], 5);
        checkOutput("step3 other leds", cntLed[0] + cntLed[2], 0);

        $display("[TB] step 4: repeated request and invalid writes");
        clearCounts();
        applyStimulus();
        requestSwap();
        repeat (3) applyStimulus();
        requestSwap();
        doWrite(3, 0, 6);
        doWrite(0, 3, 6);
        checkOutput("step4 pending mid-frame", int'(swap_pending), 1);
        waitPos(FRAME - 1);
        checkOutput("step4 no early swap_done", cntSd, 0);
        checkOutput("step4 pending at boundary", int'(swap_pending), 1);
        clearCounts();
        runFrame();
        checkOutput("step4 single swap_done", cntSd, 1);
        checkOutput("step4 led0 total", cntLed[0], 3);
        checkOutput("step4 led1 total", cntLed[1], 7);
        checkOutput("step4 led2 total", cntLed[2], 0);

        $display("[TB] step 5: request and write on last frame clock");
        waitPos(FRAME - 1);
        clearCounts();
        wr_en    = 1'b1;
        wr_led   = 2'd2;
        wr_color = 2'd2;
        wr_data  = 3'd4;
        swap_req = 1'b1;
        applyStimulus();
        wr_en    = 1'b0;
        swap_req = 1'b0;
        repeat (FRAME - 1) applyStimulus();
        checkOutput("step5 swap_done count", cntSd, 1);
        checkOutput("step5 led2 phase2", cntLP[2][2], 4);
        checkOutput("step5 led1 phase2", cntLP[1][2], 5);

        $display("[TB] step 6: reset and enable drop");
        waitPos(2 * PH_LEN + 2);
        checkOutput("step6 lit before reset", int'(ledrgb), 4);
        rst = 1'b1;
        #1;
        checkOutput("step6 outputs in reset", int'({frame_start, swap_done, swap_pending, ledrgb, ledc}), 0);
        modelReset();
        #2;
        rst = 1'b0;
        applyStimulus();
        checkOutput("step6 frame_start after reset", int'(frame_start), 1);
        clearCounts();
        requestSwap();
        waitPos(FRAME - 1);
        runFrame();
        checkOutput("step6 swap_done after reset", cntSd, 1);
        checkOutput("step6 buffers cleared", cntLed[0] + cntLed[1] + cntLed[2], 0);
        waitPos(4);
        checkOutput("step6 phase0 sink before drop", int'(ledrgb), 1);
        enable = 1'b0;
        applyStimulus();
        checkOutput("step6 outputs after enable drop", int'({ledrgb, ledc}), 0);
        repeat (2) applyStimulus();
        enable = 1'b1;
        applyStimulus();
        checkOutput("step6 frame_start on re-enable", int'(frame_start), 1);
        repeat (12) applyStimulus();
        checkOutput("step6 restart in phase0", int'(ledrgb), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
